// File: rtl/matrix_ro_pkg.sv
// Shared types and defaults for the pixel-matrix column readout controller.
package matrix_ro_pkg;

    localparam int NCOL_DEFAULT   = 56;
    localparam int WORD_W_DEFAULT = 21;
    localparam int NFLV           = 4;
    localparam int COL_W          = 6;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FREEZE,
        ST_SEL,
        ST_READ,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        FLV_PMOS_NOSF = 2'd0,
        FLV_PMOS      = 2'd1,
        FLV_COMP      = 2'd2,
        FLV_HV        = 2'd3
    } flv_t;

    // Round-robin successor; wraps from HV back to PMOS_NOSF.
    function automatic logic [1:0] nextFlv(input logic [1:0] f);
        return f + 2'd1;
    endfunction

endpackage

// File: rtl/matrix_ro_ctrl_if.sv
// Output word handshake bundle between the readout controller and its consumer.
interface matrix_ro_ctrl_if
    import matrix_ro_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
);
    logic [WORD_W-1:0] OUT_DATA;
    logic [COL_W-1:0]  OUT_COL;
    logic [1:0]        OUT_FLV;
    logic              OUT_VALID;
    logic              OUT_READY;

    modport master (
        output OUT_DATA, OUT_COL, OUT_FLV, OUT_VALID,
        input  OUT_READY
    );

    modport slave (
        input  OUT_DATA, OUT_COL, OUT_FLV, OUT_VALID,
        output OUT_READY
    );

endinterface

// File: rtl/matrix_ro_prio_enc.sv
// Lowest-index-first priority encoder over one flavour's active column tokens.
module matrix_ro_prio_enc
    import matrix_ro_pkg::*;
#(
    parameter int NCOL = NCOL_DEFAULT
) (
    input  logic [NCOL-1:0]  i_vec,
    output logic [COL_W-1:0] o_idx,
    output logic             o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = NCOL - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = COL_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/matrix_ro_ctrl.sv
// Freeze/select/read/hold readout sequencer for four pixel flavours.
// Optional HOLD stall watchdog is enabled by defining MATRIX_RO_TIMEOUT_EN.
module matrix_ro_ctrl
    import matrix_ro_pkg::*;
#(
    parameter int NCOL          = NCOL_DEFAULT,
    parameter int WORD_W        = WORD_W_DEFAULT,
    parameter int FREEZE_CYCLES = 4,
    parameter int READ_CYCLES   = 2,
    parameter int TIMEOUT       = 1023
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic [3:0]             FLV_MASK,
    input  logic [NCOL-1:0]        nTOK_PMOS_NOSF,
    input  logic [NCOL-1:0]        nTOK_PMOS,
    input  logic [NCOL-1:0]        nTOK_COMP,
    input  logic [NCOL-1:0]        nTOK_HV,
    input  logic [NCOL*WORD_W-1:0] Data_PMOS_NOSF,
    input  logic [NCOL*WORD_W-1:0] Data_PMOS,
    input  logic [NCOL*WORD_W-1:0] Data_COMP,
    input  logic [NCOL*WORD_W-1:0] Data_HV,
    output logic [NCOL-1:0]        FREEZE_PMOS_NOSF,
    output logic [NCOL-1:0]        FREEZE_PMOS,
    output logic [NCOL-1:0]        FREEZE_COMP,
    output logic [NCOL-1:0]        FREEZE_HV,
    output logic [NCOL-1:0]        Read_PMOS_NOSF,
    output logic [NCOL-1:0]        Read_PMOS,
    output logic [NCOL-1:0]        Read_COMP,
    output logic [NCOL-1:0]        Read_HV,
    output logic [WORD_W-1:0]      OUT_DATA,
    output logic [COL_W-1:0]       OUT_COL,
    output logic [1:0]             OUT_FLV,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR
);

    logic [NFLV-1:0][NCOL-1:0]        w_tok;
    logic [NFLV-1:0][NCOL*WORD_W-1:0] w_data;
    logic [NFLV-1:0][COL_W-1:0]       w_idx;
    logic [NFLV-1:0]                  w_found;
    logic                             w_anyTok;
    logic                             w_selFound;
    flv_t                             w_selFlv;
    logic [COL_W-1:0]                 w_selCol;
    logic [1:0]                       w_cand;
    logic [WORD_W-1:0]                w_word;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [1:0]                r_rrPtr;
    flv_t                      r_flv;
    logic [COL_W-1:0]          r_col;
    logic [NFLV-1:0]           r_freeze;
    logic [NFLV-1:0][NCOL-1:0] r_read;
    logic [WORD_W-1:0]         r_outData;
    logic [COL_W-1:0]          r_outCol;
    flv_t                      r_outFlv;
    logic                      r_outValid;
    logic                      r_busy;

    assign w_tok[FLV_PMOS_NOSF] = ~nTOK_PMOS_NOSF & {NCOL{FLV_MASK[FLV_PMOS_NOSF]}};
    assign w_tok[FLV_PMOS]      = ~nTOK_PMOS      & {NCOL{FLV_MASK[FLV_PMOS]}};
    assign w_tok[FLV_COMP]      = ~nTOK_COMP      & {NCOL{FLV_MASK[FLV_COMP]}};
    assign w_tok[FLV_HV]        = ~nTOK_HV        & {NCOL{FLV_MASK[FLV_HV]}};

    assign w_data[FLV_PMOS_NOSF] = Data_PMOS_NOSF;
    assign w_data[FLV_PMOS]      = Data_PMOS;
    assign w_data[FLV_COMP]      = Data_COMP;
    assign w_data[FLV_HV]        = Data_HV;

    assign w_anyTok = |w_tok;

    for (genvar f = 0; f < NFLV; f++) begin : g_enc
        matrix_ro_prio_enc #(.NCOL(NCOL)) u_enc (
            .i_vec   (w_tok[f]),
            .o_idx   (w_idx[f]),
            .o_found (w_found[f])
        );
    end

    // Scan downwards so the flavour nearest to the round-robin pointer wins.
    always_comb begin
        w_selFound = 1'b0;
        w_selFlv   = FLV_PMOS_NOSF;
        w_selCol   = '0;
        w_cand     = '0;
        for (int k = NFLV - 1; k >= 0; k--) begin
            w_cand = r_rrPtr + 2'(k);
            if (w_found[w_cand]) begin
                w_selFound = 1'b1;
                w_selFlv   = flv_t'(w_cand);
                w_selCol   = w_idx[w_cand];
            end
        end
    end

    assign w_word = w_data[r_flv][r_col*WORD_W +: WORD_W];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rrPtr    <= '0;
            r_flv      <= FLV_PMOS_NOSF;
            r_col      <= '0;
            r_freeze   <= '0;
            r_read     <= '0;
            r_outData  <= '0;
            r_outCol   <= '0;
            r_outFlv   <= FLV_PMOS_NOSF;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (EN && w_anyTok) begin
                        r_state  <= ST_FREEZE;
                        r_freeze <= FLV_MASK;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_FREEZE: begin
                    if (r_cnt == CNT_W'(FREEZE_CYCLES - 1)) begin
                        r_state <= ST_SEL;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SEL: begin
                    if (EN && w_selFound) begin
                        r_state                    <= ST_READ;
                        r_flv                      <= w_selFlv;
                        r_col                      <= w_selCol;
                        r_freeze                   <= FLV_MASK;
                        r_read[w_selFlv][w_selCol] <= 1'b1;
                        r_cnt                      <= '0;
                    end else begin
                        r_state  <= ST_RELEASE;
                        r_freeze <= '0;
                    end
                end
                ST_READ: begin
                    if (r_cnt == CNT_W'(READ_CYCLES - 1)) begin
                        r_state    <= ST_HOLD;
                        r_read     <= '0;
                        r_outData  <= w_word;
                        r_outCol   <= r_col;
                        r_outFlv   <= r_flv;
                        r_outValid <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (OUT_READY) begin
                        r_state    <= ST_SEL;
                        r_outValid <= 1'b0;
                        r_rrPtr    <= nextFlv(r_outFlv);
                    end
`ifdef MATRIX_RO_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state    <= ST_RELEASE;
                        r_outValid <= 1'b0;
                        r_freeze   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MATRIX_RO_TIMEOUT_EN
    logic r_timeoutErr;

    // Pulses during the RELEASE cycle that follows a watchdog-dropped word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_timeoutErr <= 1'b0;
        end else begin
            r_timeoutErr <= (r_state == ST_HOLD) && !OUT_READY &&
                            (r_cnt == CNT_W'(TIMEOUT - 1));
        end
    end

    assign TIMEOUT_ERR = r_timeoutErr;
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

    assign FREEZE_PMOS_NOSF = {NCOL{r_freeze[FLV_PMOS_NOSF]}};
    assign FREEZE_PMOS      = {NCOL{r_freeze[FLV_PMOS]}};
    assign FREEZE_COMP      = {NCOL{r_freeze[FLV_COMP]}};
    assign FREEZE_HV        = {NCOL{r_freeze[FLV_HV]}};

    assign Read_PMOS_NOSF = r_read[FLV_PMOS_NOSF];
    assign Read_PMOS      = r_read[FLV_PMOS];
    assign Read_COMP      = r_read[FLV_COMP];
    assign Read_HV        = r_read[FLV_HV];

    assign OUT_DATA  = r_outData;
    assign OUT_COL   = r_outCol;
    assign OUT_FLV   = r_outFlv;
    assign OUT_VALID = r_outValid;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_matrix_ro_ctrl.sv
// Directed self-checking bench for matrix_ro_ctrl; define MATRIX_RO_TIMEOUT_EN
// to exercise the HOLD watchdog with TIMEOUT=8.
module tb_matrix_ro_ctrl;

    localparam int NCOL   = 56;
    localparam int WORD_W = 21;
`ifdef MATRIX_RO_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 1023;
`endif

    logic                   CLK;
    logic                   RST;
    logic                   EN;
    logic [3:0]             FLV_MASK;
    logic [NCOL-1:0]        nTOK_PMOS_NOSF, nTOK_PMOS, nTOK_COMP, nTOK_HV;
    logic [NCOL*WORD_W-1:0] Data_PMOS_NOSF, Data_PMOS, Data_COMP, Data_HV;
    logic [NCOL-1:0]        FREEZE_PMOS_NOSF, FREEZE_PMOS, FREEZE_COMP, FREEZE_HV;
    logic [NCOL-1:0]        Read_PMOS_NOSF, Read_PMOS, Read_COMP, Read_HV;
    logic                   BUSY;
    logic                   TIMEOUT_ERR;

    int checks   = 0;
    int failures = 0;

    matrix_ro_ctrl_if #(.WORD_W(WORD_W)) u_out ();

    matrix_ro_ctrl #(
        .NCOL          (NCOL),
        .WORD_W        (WORD_W),
        .FREEZE_CYCLES (4),
        .READ_CYCLES   (2),
        .TIMEOUT       (TB_TIMEOUT)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .EN               (EN),
        .FLV_MASK         (FLV_MASK),
        .nTOK_PMOS_NOSF   (nTOK_PMOS_NOSF),
        .nTOK_PMOS        (nTOK_PMOS),
        .nTOK_COMP        (nTOK_COMP),
        .nTOK_HV          (nTOK_HV),
        .Data_PMOS_NOSF   (Data_PMOS_NOSF),
        .Data_PMOS        (Data_PMOS),
        .Data_COMP        (Data_COMP),
        .Data_HV          (Data_HV),
        .FREEZE_PMOS_NOSF (FREEZE_PMOS_NOSF),
        .FREEZE_PMOS      (FREEZE_PMOS),
        .FREEZE_COMP      (FREEZE_COMP),
        .FREEZE_HV        (FREEZE_HV),
        .Read_PMOS_NOSF   (Read_PMOS_NOSF),
        .Read_PMOS        (Read_PMOS),
        .Read_COMP        (Read_COMP),
        .Read_HV          (Read_HV),
        .OUT_DATA         (u_out.OUT_DATA),
        .OUT_COL          (u_out.OUT_COL),
        .OUT_FLV          (u_out.OUT_FLV),
        .OUT_VALID        (u_out.OUT_VALID),
        .OUT_READY        (u_out.OUT_READY),
        .BUSY             (BUSY),
        .TIMEOUT_ERR      (TIMEOUT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int f, input int c, input logic nTok,
                                 input logic [WORD_W-1:0] word);
        case (f)
            0: begin nTOK_PMOS_NOSF[c] = nTok; Data_PMOS_NOSF[c*WORD_W +: WORD_W] = word; end
            1: begin nTOK_PMOS[c]      = nTok; Data_PMOS[c*WORD_W +: WORD_W]      = word; end
            2: begin nTOK_COMP[c]      = nTok; Data_COMP[c*WORD_W +: WORD_W]      = word; end
            default: begin nTOK_HV[c]  = nTok; Data_HV[c*WORD_W +: WORD_W]        = word; end
        endcase
    endtask

    task automatic waitValid(input string tag, input int maxCycles);
        int n = 0;
        do begin
            tick();
            n++;
        end while (u_out.OUT_VALID !== 1'b1 && n < maxCycles);
        checkOutput({tag, "_valid"}, 64'(u_out.OUT_VALID), 64'd1);
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        int n = 0;
        do begin
            tick();
            n++;
        end while (BUSY !== 1'b0 && n < maxCycles);
        checkOutput({tag, "_idle"}, 64'(BUSY), 64'd0);
    endtask

    task automatic doReset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        logic [NCOL-1:0] ones;
        logic [NCOL-1:0] col55;
        logic            stable;
        int              n;

        ones           = '1;
        col55          = {1'b1, 55'd0};
        EN             = 1'b1;
        FLV_MASK       = 4'hF;
        nTOK_PMOS_NOSF = '1;
        nTOK_PMOS      = '1;
        nTOK_COMP      = '1;
        nTOK_HV        = '1;
        Data_PMOS_NOSF = '0;
        Data_PMOS      = '0;
        Data_COMP      = '0;
        Data_HV        = '0;
        u_out.OUT_READY = 1'b0;

        RST = 1'b1;
        tick();
        tick();
        checkOutput("rst_busy",   64'(BUSY), 64'd0);
        checkOutput("rst_valid",  64'(u_out.OUT_VALID), 64'd0);
        checkOutput("rst_freeze", 64'(FREEZE_COMP), 64'd0);
        checkOutput("rst_data",   64'(u_out.OUT_DATA), 64'd0);
        checkOutput("rst_terr",   64'(TIMEOUT_ERR), 64'd0);
        RST = 1'b0;

        $display("[TB] single token, COMP column 55");
        applyStimulus(2, 55, 1'b0, 21'h1ABCD);
        u_out.OUT_READY = 1'b1;
        tick();
        checkOutput("c55_busy", 64'(BUSY), 64'd1);
        checkOutput("c55_frz_pmos", 64'(FREEZE_PMOS), 64'(ones));
        for (int i = 0; i < 4; i++) begin
            checkOutput("c55_frz_comp", 64'(FREEZE_COMP), 64'(ones));
            checkOutput("c55_noread", 64'(Read_COMP), 64'd0);
            tick();
        end
        checkOutput("c55_sel_frz", 64'(FREEZE_COMP), 64'(ones));
        tick();
        checkOutput("c55_read1", 64'(Read_COMP), 64'(col55));
        tick();
        checkOutput("c55_read2", 64'(Read_COMP), 64'(col55));
        applyStimulus(2, 55, 1'b1, 21'h1ABCD);
        tick();
        checkOutput("c55_read_off", 64'(Read_COMP), 64'd0);
        checkOutput("c55_valid", 64'(u_out.OUT_VALID), 64'd1);
        checkOutput("c55_data",  64'(u_out.OUT_DATA), 64'h1ABCD);
        checkOutput("c55_col",   64'(u_out.OUT_COL), 64'd55);
        checkOutput("c55_flv",   64'(u_out.OUT_FLV), 64'd2);
        tick();
        checkOutput("c55_sel_valid", 64'(u_out.OUT_VALID), 64'd0);
        tick();
        checkOutput("c55_rel_frz", 64'(FREEZE_COMP), 64'd0);
        checkOutput("c55_rel_busy", 64'(BUSY), 64'd1);
        tick();
        checkOutput("c55_idle", 64'(BUSY), 64'd0);

        $display("[TB] two PMOS tokens, lowest column first");
        applyStimulus(1, 3, 1'b0, 21'h00333);
        applyStimulus(1, 7, 1'b0, 21'h00777);
        waitValid("pm3", 20);
        checkOutput("pm3_col",  64'(u_out.OUT_COL), 64'd3);
        checkOutput("pm3_data", 64'(u_out.OUT_DATA), 64'h00333);
        applyStimulus(1, 3, 1'b1, 21'h00333);
        waitValid("pm7", 20);
        checkOutput("pm7_col",  64'(u_out.OUT_COL), 64'd7);
        checkOutput("pm7_data", 64'(u_out.OUT_DATA), 64'h00777);
        applyStimulus(1, 7, 1'b1, 21'h00777);
        waitIdle("pm", 20);

        $display("[TB] column 0 in all flavours, round robin");
        doReset();
        for (int f = 0; f < 4; f++) applyStimulus(f, 0, 1'b0, 21'(32'h10 + f));
        for (int f = 0; f < 4; f++) begin
            waitValid("rr", 30);
            checkOutput("rr_flv",  64'(u_out.OUT_FLV), 64'(f));
            checkOutput("rr_data", 64'(u_out.OUT_DATA), 64'(32'h10 + f));
            checkOutput("rr_col",  64'(u_out.OUT_COL), 64'd0);
            applyStimulus(f, 0, 1'b1, 21'(32'h10 + f));
        end
        tick();
        checkOutput("rr_sel_busy", 64'(BUSY), 64'd1);
        tick();
        checkOutput("rr_rel_frz", 64'(FREEZE_HV), 64'd0);
        checkOutput("rr_rel_busy", 64'(BUSY), 64'd1);
        tick();
        checkOutput("rr_idle", 64'(BUSY), 64'd0);

`ifndef MATRIX_RO_TIMEOUT_EN
        $display("[TB] backpressure for 20 HOLD cycles");
        u_out.OUT_READY = 1'b0;
        applyStimulus(3, 10, 1'b0, 21'h15555);
        waitValid("bp", 20);
        stable = 1'b1;
        for (int i = 0; i < 19; i++) begin
            tick();
            if (u_out.OUT_VALID !== 1'b1 || u_out.OUT_DATA !== 21'h15555 ||
                u_out.OUT_COL !== 6'd10 || u_out.OUT_FLV !== 2'd3) stable = 1'b0;
        end
        checkOutput("bp_stable", 64'(stable), 64'd1);
        checkOutput("bp_terr", 64'(TIMEOUT_ERR), 64'd0);
        checkOutput("bp_frz", 64'(FREEZE_HV), 64'(ones));
        applyStimulus(3, 10, 1'b1, 21'h15555);
        u_out.OUT_READY = 1'b1;
        tick();
        checkOutput("bp_xfer", 64'(u_out.OUT_VALID), 64'd0);
        waitIdle("bp", 20);
`else
        $display("[TB] HOLD watchdog, TIMEOUT=8");
        u_out.OUT_READY = 1'b0;
        applyStimulus(2, 0, 1'b0, 21'h0BEEF);
        waitValid("to", 20);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("to_hold8_valid", 64'(u_out.OUT_VALID), 64'd1);
        checkOutput("to_hold8_terr", 64'(TIMEOUT_ERR), 64'd0);
        applyStimulus(2, 0, 1'b1, 21'h0BEEF);
        tick();
        checkOutput("to_terr", 64'(TIMEOUT_ERR), 64'd1);
        checkOutput("to_valid", 64'(u_out.OUT_VALID), 64'd0);
        checkOutput("to_frz", 64'(FREEZE_COMP), 64'd0);
        tick();
        checkOutput("to_terr_pulse", 64'(TIMEOUT_ERR), 64'd0);
        checkOutput("to_idle", 64'(BUSY), 64'd0);
        u_out.OUT_READY = 1'b1;
`endif

        $display("[TB] all flavours masked off");
        FLV_MASK = 4'b0000;
        for (int f = 0; f < 4; f++) applyStimulus(f, 5, 1'b0, 21'h00055);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("mask_busy", 64'(BUSY), 64'd0);
        checkOutput("mask_frz", 64'(FREEZE_PMOS), 64'd0);
        for (int f = 0; f < 4; f++) applyStimulus(f, 5, 1'b1, 21'h00055);

        $display("[TB] reset during READ");
        FLV_MASK = 4'hF;
        applyStimulus(0, 20, 1'b0, 21'h0ACE1);
        n = 0;
        do begin
            tick();
            n++;
        end while (Read_PMOS_NOSF === '0 && n < 20);
        checkOutput("rstrd_read", 64'(Read_PMOS_NOSF), 64'(56'd1 << 20));
        RST = 1'b1;
        tick();
        checkOutput("rstrd_read_off", 64'(Read_PMOS_NOSF), 64'd0);
        checkOutput("rstrd_frz", 64'(FREEZE_PMOS_NOSF), 64'd0);
        checkOutput("rstrd_busy", 64'(BUSY), 64'd0);
        checkOutput("rstrd_valid", 64'(u_out.OUT_VALID), 64'd0);
        checkOutput("rstrd_data", 64'(u_out.OUT_DATA), 64'd0);
        RST = 1'b0;
        applyStimulus(0, 20, 1'b1, 21'h0ACE1);
        tick();
        checkOutput("rstrd_stay_idle", 64'(BUSY), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_ro_ctrl.md
MATRIX_RO_CTRL -- requirements
Module: matrix_ro_ctrl

Interface
REQ-001 SHALL have parameter NCOL, 56, number of double-columns per flavour.
REQ-002 SHALL have parameter WORD_W, 21, data word width per column; Data bus width is NCOL*WORD_W.
REQ-003 SHALL have parameter FREEZE_CYCLES, 4, settle cycles after FREEZE assertion.
REQ-004 SHALL have parameter READ_CYCLES, 2, Read pulse length.
REQ-005 SHALL have parameter TIMEOUT, 1023, stall limit in cycles; used only with the macro.
REQ-006 SHALL have port CLK  in  1  sole clock, rising edge.
REQ-007 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port EN  in  1  readout enable.
REQ-009 SHALL have port FLV_MASK  in  4  per-flavour enable; bit 0 PMOS_NOSF, 1 PMOS, 2 COMP, 3 HV.
REQ-010 SHALL have ports nTOK_PMOS_NOSF, nTOK_PMOS, nTOK_COMP, nTOK_HV  in  NCOL  column tokens, active-low.
REQ-011 SHALL have ports Data_PMOS_NOSF, Data_PMOS, Data_COMP, Data_HV  in  NCOL*WORD_W  column data; column c at bits [c*WORD_W +: WORD_W].
REQ-012 SHALL have ports FREEZE_PMOS_NOSF, FREEZE_PMOS, FREEZE_COMP, FREEZE_HV  out  NCOL  column freeze.
REQ-013 SHALL have ports Read_PMOS_NOSF, Read_PMOS, Read_COMP, Read_HV  out  NCOL  column read strobe.
REQ-014 SHALL have port OUT_DATA  out  WORD_W  captured word.
REQ-015 SHALL have port OUT_COL  out  6  column index of OUT_DATA.
REQ-016 SHALL have port OUT_FLV  out  2  flavour index of OUT_DATA.
REQ-017 SHALL have port OUT_VALID  out  1 and OUT_READY  in  1  output handshake.
REQ-018 SHALL have ports BUSY  out  1 (state not IDLE) and TIMEOUT_ERR  out  1.

Function
REQ-019 Token active for column c of flavour f SHALL mean nTOK_f[c]==0 and FLV_MASK[f]==1.
REQ-020 FSM states SHALL be IDLE, FREEZE, SEL, READ, HOLD, RELEASE.
REQ-021 IDLE -> FREEZE SHALL occur when EN==1 and any token is active; otherwise stay IDLE.
REQ-022 In FREEZE, SEL, READ, HOLD all FREEZE bits of masked-in flavours SHALL be 1; all FREEZE bits SHALL be 0 in IDLE and RELEASE.
REQ-023 FREEZE SHALL last exactly FREEZE_CYCLES cycles, then go to SEL.
REQ-024 SEL SHALL last one cycle: flavour chosen round-robin starting at RR_PTR, column = lowest index with active token in that flavour; if none or EN==0, go to RELEASE.
REQ-025 READ SHALL assert exactly one Read bit (chosen flavour/column) for READ_CYCLES cycles; the Data word SHALL be captured on the last READ cycle; then HOLD.
REQ-026 In HOLD OUT_VALID SHALL be 1 with OUT_DATA/OUT_COL/OUT_FLV stable; on OUT_VALID&&OUT_READY go to SEL and advance RR_PTR to served flavour+1 (mod 4).
REQ-027 OUT_READY already high at HOLD entry SHALL complete the transfer in that cycle (one HOLD cycle minimum).
REQ-028 RELEASE SHALL last one cycle then go to IDLE.
REQ-029 Tokens and FLV_MASK SHALL be sampled only in IDLE and SEL; changes elsewhere take effect at next SEL.
REQ-030 Column 0 and column NCOL-1 SHALL be handled identically; simultaneous tokens in all four flavours SHALL be served one word per flavour in RR order.

Reset
REQ-031 On RST==1 at a CLK edge the state SHALL become IDLE, RR_PTR 0, all outputs 0, including mid-READ or mid-HOLD (word dropped).

Configuration
REQ-032 With MATRIX_RO_TIMEOUT_EN defined, a counter SHALL count consecutive HOLD cycles without OUT_READY; reaching TIMEOUT SHALL drop the word, go to RELEASE and pulse TIMEOUT_ERR for one cycle.
REQ-033 Without MATRIX_RO_TIMEOUT_EN, TIMEOUT_ERR SHALL be tied 0 and HOLD SHALL wait indefinitely.

Structure
REQ-034 Package matrix_ro_pkg SHALL hold the state enum, flavour enum/indices, NCOL and WORD_W defaults.
REQ-035 Sub-module matrix_ro_prio_enc SHALL implement the NCOL-wide lowest-index priority encoder (index plus found flag), instantiated once per flavour.

Verification
REQ-036 RST, then nTOK_COMP[55]=0, Data_COMP[55] word=0x1ABCD, OUT_READY=1 -> FREEZE_COMP all 1 for 4+ cycles, Read_COMP[55] 2 cycles, OUT_DATA=0x1ABCD, OUT_COL=55, OUT_FLV=2.
REQ-037 nTOK_PMOS[3]=0 and nTOK_PMOS[7]=0 -> column 3 word first, then column 7.
REQ-038 Token in column 0 of all four flavours, RR_PTR=0 -> OUT_FLV sequence 0,1,2,3, then RELEASE, IDLE.
REQ-039 OUT_READY held 0 for 20 cycles in HOLD -> OUT_VALID and outputs stable 20 cycles; transfer on first READY cycle.
REQ-040 FLV_MASK=4'b0000 with tokens active -> stays IDLE, BUSY=0; RST asserted during READ -> all outputs 0 next cycle.
REQ-041 With MATRIX_RO_TIMEOUT_EN, TIMEOUT=8, OUT_READY=0 -> TIMEOUT_ERR one-cycle pulse after 8 HOLD cycles, OUT_VALID 0, FREEZE released.
